// File: rtl/video_stream_source_if.sv
// Raster video bundle: frame / line / data-valid strobes,
// pixel byte and linear pixel index, driven by the source.
interface video_stream_source_if;
  logic        video_frame_valid;
  logic        video_line_valid;
  logic        video_data_valid;
  logic [7:0]  video_data_out;
  logic [19:0] video_address;

  modport master (
    output video_frame_valid,
    output video_line_valid,
    output video_data_valid,
    output video_data_out,
    output video_address
  );

  modport slave (
    input video_frame_valid,
    input video_line_valid,
    input video_data_valid,
    input video_data_out,
    input video_address
  );
endinterface

// File: rtl/video_stream_source.sv
// Raster video transmitter: timing FSM, frame-memory reader
// and test-pattern generator behind a 2-stage output pipe.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           one-cycle frame start (idle only)
//   continuous      repeat frames back-to-back while high
//   mode            00 mem, 01 hramp, 10 checker, 11 vramp
//   mem_addr        frame-memory read address
//   mem_rdata       memory data, one cycle after mem_addr
//   busy            high from accepted start to frame end
//   frame_done      one-cycle pulse when frame valid drops
//   vid             video stream (master side)
module video_stream_source #(
  parameter int H_ACTIVE = 702,
  parameter int V_ACTIVE = 288,
  parameter int H_BLANK  = 162,
  parameter int V_BLANK  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  mode,
  output logic [19:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        frame_done,
  video_stream_source_if.master vid
);

  localparam int LINE = H_ACTIVE + H_BLANK;

  localparam logic [9:0] H_LAST  = 10'(LINE - 1);
  localparam logic [9:0] HB      = 10'(H_BLANK);
  localparam logic [7:0] HB8     = 8'(H_BLANK);
  localparam logic [9:0] VB_LAST = 10'(V_BLANK - 1);
  localparam logic [9:0] VA_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  // With no vertical blanking a frame opens straight
  // into its first active line.
  localparam state_t S_FIRST =
    (V_BLANK == 0) ? S_ACTIVE : S_VBLANK;

  // Stage 0: timing state
  state_t      r_state;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [19:0] r_addr;
  logic [1:0]  r_mode;
  logic        r_busy;

  logic w_line_end;
  logic w_pix;
  logic w_last;

  assign w_line_end = (r_h == H_LAST);
  assign w_pix      = (r_state == S_ACTIVE) && (r_h >= HB);
  assign w_last     = w_pix && w_line_end &&
                      (r_v == VA_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_addr  <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FIRST;
            r_h     <= '0;
            r_v     <= '0;
            r_addr  <= '0;
            r_mode  <= mode;
            r_busy  <= 1'b1;
          end
        end
        S_VBLANK: begin
          if (w_line_end) begin
            r_h <= '0;
            if (r_v == VB_LAST) begin
              r_v     <= '0;
              r_state <= S_ACTIVE;
            end else begin
              r_v <= r_v + 10'd1;
            end
          end else begin
            r_h <= r_h + 10'd1;
          end
        end
        S_ACTIVE: begin
          // Running pixel index replaces y*H_ACTIVE+x.
          if (w_pix) r_addr <= r_addr + 20'd1;
          if (w_line_end) begin
            r_h <= '0;
            r_v <= r_v + 10'd1;
          end else begin
            r_h <= r_h + 10'd1;
          end
          if (w_last) begin
            r_v    <= '0;
            r_addr <= '0;
            if (continuous) begin
              r_state <= S_FIRST;
              r_mode  <= mode;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign busy     = r_busy;

  // Stage 1: control aligned with the memory read.
  // Only the low bytes of x/y feed the patterns.
  logic        r_s1_fa;
  logic        r_s1_la;
  logic [7:0]  r_s1_x;
  logic [7:0]  r_s1_y;
  logic [19:0] r_s1_addr;
  logic [1:0]  r_s1_mode;
  logic        r_s1_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_fa   <= 1'b0;
      r_s1_la   <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_addr <= '0;
      r_s1_mode <= '0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_fa   <= (r_state == S_ACTIVE);
      r_s1_la   <= w_pix;
      r_s1_x    <= r_h[7:0] - HB8;
      r_s1_y    <= r_v[7:0];
      r_s1_addr <= r_addr;
      // Mode travels with the pixel so a frame
      // boundary never retags pixels in flight.
      r_s1_mode <= r_mode;
      r_s1_last <= w_last;
    end
  end

  logic [7:0] w_pat;

  always_comb begin
    w_pat = '0;
    unique case (r_s1_mode)
      2'b00: w_pat = mem_rdata;
      2'b01: w_pat = r_s1_x;
      2'b10: w_pat = (r_s1_x[3] ^ r_s1_y[3]) ?
                     8'hFF : 8'h00;
      2'b11: w_pat = r_s1_y;
    endcase
  end

  // Stage 2: port registers
  logic        r_fv;
  logic        r_lv;
  logic        r_dv;
  logic [7:0]  r_data;
  logic [19:0] r_vaddr;
  logic        r_s2_last;
  logic        r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fv      <= 1'b0;
      r_lv      <= 1'b0;
      r_dv      <= 1'b0;
      r_data    <= '0;
      r_vaddr   <= '0;
      r_s2_last <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fv      <= r_s1_fa;
      r_lv      <= r_s1_la;
      r_dv      <= r_s1_la;
      r_data    <= r_s1_la ? w_pat : 8'h00;
      r_vaddr   <= r_s1_la ? r_s1_addr : 20'h0;
      r_s2_last <= r_s1_last;
      // Lands one cycle after the last pixel, where
      // frame valid drops at the ports.
      r_done    <= r_s2_last;
    end
  end

  assign frame_done = r_done;

  assign vid.video_frame_valid = r_fv;
  assign vid.video_line_valid  = r_lv;
  assign vid.video_data_valid  = r_dv;
  assign vid.video_data_out    = r_data;
  assign vid.video_address     = r_vaddr;

endmodule

// File: tb/tb_video_stream_source.sv
// Bench for video_stream_source: vector table, directed
// corner sequences and random frames against a raster model.
module tb_video_stream_source;

  logic clk;
  logic rstA, rstB;
  logic startA, startB;
  logic contA, contB;
  logic [1:0] modeA, modeB;
  logic [19:0] maddrA, maddrB;
  logic [7:0] mrdA, mrdB;
  logic busyA, busyB;
  logic doneA, doneB;

  video_stream_source_if vifA ();
  video_stream_source_if vifB ();

  video_stream_source #(
    .H_ACTIVE(8), .V_ACTIVE(4),
    .H_BLANK(3), .V_BLANK(2)
  ) dutA (
    .clk(clk), .reset(rstA), .start(startA),
    .continuous(contA), .mode(modeA),
    .mem_addr(maddrA), .mem_rdata(mrdA),
    .busy(busyA), .frame_done(doneA), .vid(vifA)
  );

  video_stream_source #(
    .H_ACTIVE(16), .V_ACTIVE(16),
    .H_BLANK(3), .V_BLANK(0)
  ) dutB (
    .clk(clk), .reset(rstB), .start(startB),
    .continuous(contB), .mode(modeB),
    .mem_addr(maddrB), .mem_rdata(mrdB),
    .busy(busyB), .frame_done(doneB), .vid(vifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    mrdA <= mem[maddrA[7:0]];
    mrdB <= mem[maddrB[7:0]];
  end

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic        dv;
    logic [7:0]  data;
    logic [19:0] addr;
    logic        busy;
    logic        done;
    logic [19:0] maddr;
  } obs_t;

  typedef struct {
    int          k;
    logic        fv, lv, dv;
    logic [7:0]  data;
    logic [19:0] addr;
    logic        busy, done;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t trace[$];

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.fv = vifA.video_frame_valid;
      o.lv = vifA.video_line_valid;
      o.dv = vifA.video_data_valid;
      o.data = vifA.video_data_out;
      o.addr = vifA.video_address;
      o.busy = busyA; o.done = doneA;
      o.maddr = maddrA;
    end else begin
      o.fv = vifB.video_frame_valid;
      o.lv = vifB.video_line_valid;
      o.dv = vifB.video_data_valid;
      o.data = vifB.video_data_out;
      o.addr = vifB.video_address;
      o.busy = busyB; o.done = doneB;
      o.maddr = maddrB;
    end
    return o;
  endfunction

  // Raster model: k counts cycles after the start edge.
  // Stage-0 position is k, ports show position k-2.
  function automatic obs_t model(input int sel,
      input int nf, input logic [1:0] m, input int k);
    obs_t o;
    int H, V, HB, VB, L, P, tot, t, a, b, y, h, x, j;
    H  = (sel == 0) ? 8 : 16;
    V  = (sel == 0) ? 4 : 16;
    HB = 3;
    VB = (sel == 0) ? 2 : 0;
    L = H + HB; P = (VB + V) * L; tot = nf * P;
    o = '0;
    o.busy = (k < tot);
    if (k < tot) begin
      a = k % P;
      if (a >= VB * L) begin
        b = a - VB * L; y = b / L; h = b % L;
        o.maddr = 20'(y * H + ((h < HB) ? 0 : h - HB));
      end
    end
    t = k - 2;
    if (t >= 0 && t < tot) begin
      a = t % P;
      if (a >= VB * L) begin
        b = a - VB * L; y = b / L; h = b % L;
        o.fv = 1'b1;
        if (h >= HB) begin
          x = h - HB;
          o.lv = 1'b1; o.dv = 1'b1;
          o.addr = 20'(y * H + x);
          case (m)
            2'b00: o.data = mem[o.addr[7:0]];
            2'b01: o.data = 8'(x);
            2'b10: o.data =
              (((x / 8) % 2) != ((y / 8) % 2)) ? 8'd255 : 8'd0;
            default: o.data = 8'(y);
          endcase
        end
      end
    end
    j = k - 3;
    o.done = (j >= 0 && j < tot && (j % P) == P - 1);
    return o;
  endfunction

  task automatic chk(input string nm, input int k,
      input obs_t g, input obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s k=%0d got fv%b lv%b dv%b d=%0d a=%0d bsy%b dn%b ma=%0d req fv%b lv%b dv%b d=%0d a=%0d bsy%b dn%b ma=%0d",
        nm, k, g.fv, g.lv, g.dv, g.data, g.addr, g.busy,
        g.done, g.maddr, e.fv, e.lv, e.dv, e.data, e.addr,
        e.busy, e.done, e.maddr);
    end
  endtask

  task automatic chk_val(input string nm, input int g,
      input int e);
    n_cmp++;
    if (g != e) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", nm, g, e);
    end
  endtask

  task automatic drive(input int sel, input logic s,
      input logic c, input logic [1:0] md);
    if (sel == 0) begin
      startA = s; contA = c; modeA = md;
    end else begin
      startB = s; contB = c; modeB = md;
    end
  endtask

  task automatic run_check(input string nm, input int sel,
      input int nf, input logic [1:0] m,
      input int restart_at, input bit scramble);
    int P, tot;
    obs_t g, e;
    logic c;
    logic [1:0] md;
    P = (sel == 0) ? 66 : 304;
    tot = nf * P;
    trace.delete();
    c = (nf > 1);
    md = m;
    @(negedge clk);
    drive(sel, 1'b1, c, m);
    for (int k = 0; k < tot + 12; k++) begin
      @(negedge clk);
      g = sample(sel);
      e = model(sel, nf, m, k);
      trace.push_back(g);
      chk(nm, k, g, e);
      if (nf > 1 && k == (nf - 1) * P + 10) c = 1'b0;
      if (scramble) md = 2'($urandom);
      drive(sel, (k == restart_at), c, md);
    end
    drive(sel, 1'b0, 1'b0, m);
  endtask

  vec_t vt[$];
  obs_t g;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rstA = 1'b1; rstB = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00);
    drive(1, 1'b0, 1'b0, 2'b00);

    // Frame 1 checkpoints, mode 01, k = cycles after E0
    vt.push_back('{0,  0,0,0, 8'd0, 20'd0,  1,0});
    vt.push_back('{23, 0,0,0, 8'd0, 20'd0,  1,0});
    vt.push_back('{24, 1,0,0, 8'd0, 20'd0,  1,0});
    vt.push_back('{26, 1,0,0, 8'd0, 20'd0,  1,0});
    vt.push_back('{27, 1,1,1, 8'd0, 20'd0,  1,0});
    vt.push_back('{34, 1,1,1, 8'd7, 20'd7,  1,0});
    vt.push_back('{35, 1,0,0, 8'd0, 20'd0,  1,0});
    vt.push_back('{38, 1,1,1, 8'd0, 20'd8,  1,0});
    vt.push_back('{65, 1,1,1, 8'd5, 20'd29, 1,0});
    vt.push_back('{67, 1,1,1, 8'd7, 20'd31, 0,0});
    vt.push_back('{68, 0,0,0, 8'd0, 20'd0,  0,1});
    vt.push_back('{69, 0,0,0, 8'd0, 20'd0,  0,0});

    // Reset state, during and the cycle after
    repeat (3) @(negedge clk);
    chk("rst_A", 0, sample(0), '0);
    chk("rst_B", 0, sample(1), '0);
    rstA = 1'b0; rstB = 1'b0;
    @(negedge clk);
    chk("post_rst_A", 0, sample(0), '0);
    chk("post_rst_B", 0, sample(1), '0);

    // 1: frame timing with horizontal ramp
    run_check("t1_frame", 0, 1, 2'b01, -1, 1'b0);
    foreach (vt[i]) begin
      g = trace[vt[i].k];
      n_cmp++;
      if (g.fv !== vt[i].fv || g.lv !== vt[i].lv ||
          g.dv !== vt[i].dv || g.data !== vt[i].data ||
          g.addr !== vt[i].addr || g.busy !== vt[i].busy ||
          g.done !== vt[i].done) begin
        n_bad++;
        $display("FAIL t1_vec k=%0d got %b%b%b d=%0d a=%0d b%b dn%b req %b%b%b d=%0d a=%0d b%b dn%b",
          vt[i].k, g.fv, g.lv, g.dv, g.data, g.addr, g.busy,
          g.done, vt[i].fv, vt[i].lv, vt[i].dv, vt[i].data,
          vt[i].addr, vt[i].busy, vt[i].done);
      end
    end

    // 2: memory mode, stray start and mode changes mid-frame
    run_check("t2_mem", 0, 1, 2'b00, 40, 1'b1);

    // 3: continuous, cleared during frame 2
    run_check("t3_cont", 0, 2, 2'b01, -1, 1'b0);
    begin
      int nd, k1, k2, k3, k4;
      nd = 0; k1 = -1; k2 = -1; k3 = -1; k4 = -1;
      foreach (trace[i]) begin
        if (trace[i].done) nd++;
        if (k1 < 0 && trace[i].dv && trace[i].addr == 31)
          k1 = i;
        else if (k1 >= 0 && k2 < 0 && trace[i].dv)
          k2 = i;
        if (k1 >= 0 && k3 < 0 && !trace[i].fv) k3 = i;
        else if (k3 >= 0 && k4 < 0 && trace[i].fv) k4 = i;
      end
      chk_val("t3_done_pulses", nd, 2);
      chk_val("t3_dv_gap", k2 - k1 - 1, 25);
      chk_val("t3_fv_gap", k4 - k3, 22);
      chk_val("t3_idle_busy",
        int'(trace[trace.size() - 1].busy), 0);
    end

    // 4: checkerboard, no vertical blanking
    run_check("t4_chk", 1, 1, 2'b10, -1, 1'b0);
    chk_val("t4_fv_k1", int'(trace[1].fv), 0);
    chk_val("t4_fv_k2", int'(trace[2].fv), 1);
    begin
      int d8, d0, d136;
      d8 = -1; d0 = -1; d136 = -1;
      foreach (trace[i]) begin
        if (trace[i].dv) begin
          if (trace[i].addr == 8) d8 = trace[i].data;
          if (trace[i].addr == 0) d0 = trace[i].data;
          if (trace[i].addr == 136) d136 = trace[i].data;
        end
      end
      chk_val("t4_px_8_0", d8, 255);
      chk_val("t4_px_0_0", d0, 0);
      chk_val("t4_px_8_8", d136, 0);
    end

    // 5: reset at active pixel 5 of the first line
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b01);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, 1'b0, 1'b0, 2'b01);
      if (k == 30) rstA = 1'b1;
    end
    @(negedge clk);
    rstA = 1'b0;
    chk("t5_rst", 31, sample(0), '0);
    for (int k = 32; k < 40; k++) begin
      @(negedge clk);
      chk("t5_quiet", k, sample(0), '0);
    end
    run_check("t5_after", 0, 1, 2'b11, -1, 1'b0);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      logic [1:0] m;
      int nf, rs;
      m = 2'($urandom_range(0, 3));
      nf = $urandom_range(1, 2);
      rs = $urandom_range(1, nf * 66 - 2);
      for (int i = 0; i < 256; i++)
        mem[i] = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_check("rnd", 0, nf, m, rs, nf == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
